// File: rtl/hid_pkg.sv
// rtl/hid_pkg.sv - shared constants, state encodings and command record for hid_packet_rx (HID_CHECKSUM_EN adds P_CHK)
package hid_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         CMD_W_DEF   = 3;
  localparam int         COORD_W_DEF = 6;

  // Parser position inside a packet; P_CHK only exists with the checksum byte
  typedef enum logic [2:0] {
    P_IDLE,
    P_CMD,
    P_XB,
    P_YB
`ifdef HID_CHECKSUM_EN
    ,
    P_CHK
`endif
  } parse_state_t;

  // UART receiver position inside a character
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_t;

  // Decoded command record at the default field widths
  typedef struct packed {
    logic [CMD_W_DEF-1:0]   cmd;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } hid_cmd_t;

  // True when byte b is representable in w bits
  function automatic logic fits_width(input logic [7:0] b, input int w);
    return (w >= 8) || ((b >> w) == 8'd0);
  endfunction

endpackage

// File: rtl/hid_cmd_fifo.sv
// rtl/hid_cmd_fifo.sv - synchronous FIFO for decoded commands, read-before-write when full
module hid_cmd_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hid_packet_rx.sv
// rtl/hid_packet_rx.sv - UART 8N1 receiver and sync-prefixed packet parser feeding a command FIFO (HID_CHECKSUM_EN adds a CMD^X^Y checksum byte)
module hid_packet_rx
  import hid_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD_RATE     = 9600,
  parameter int CMD_W         = 3,
  parameter int COORD_W       = 6,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [CMD_W-1:0]   cmd_id,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               overflow,
  output logic [7:0]         err_count
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TICK_W     = $clog2(BIT_TICKS + 1);
  localparam int TMO_LIMIT  = TIMEOUT_BYTES * 10 * BIT_TICKS;
  localparam int TMO_W      = $clog2(TMO_LIMIT + 1);
  localparam int ENTRY_W    = CMD_W + 2 * COORD_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_TICKS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

  logic rx_meta, rx_sync, rx_prev;

  uart_state_t       u_state_q, u_state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              byte_stb_q, byte_stb_d;
  logic              frame_err_q, frame_err_d;

  parse_state_t      p_state_q, p_state_d;
  logic [7:0]        cmd_b_q, cmd_b_d;
  logic [7:0]        x_b_q, x_b_d;
  logic [7:0]        y_b_q, y_b_d;
  logic [7:0]        y_fin;
  logic [TMO_W-1:0]  tmo_q;
  logic              pkt_done, tmo_hit, chk_ok, ranges_ok, accept, reject, err_inc;

  logic               push_q;
  logic [ENTRY_W-1:0] push_data_q;
  logic [ENTRY_W-1:0] fifo_rd;
  logic               fifo_full, fifo_empty, pop;

  // Two-flop synchroniser plus one history flop for falling-edge detection, idle high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // UART receiver state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state_q   <= RX_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      rx_byte_q   <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      u_state_q   <= u_state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      rx_byte_q   <= rx_byte_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  // UART next state: mid-bit sampling, start re-check rejects glitches, low stop bit is a framing error
  always_comb begin
    u_state_d   = u_state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    rx_byte_d   = rx_byte_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    case (u_state_q)
      RX_IDLE: begin
        tick_d = '0;
        if (rx_prev && !rx_sync) u_state_d = RX_START;
      end
      RX_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d    = '0;
          bit_d     = '0;
          u_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shreg_d = {rx_sync, shreg_q[7:1]};
          if (bit_q == 3'd7) u_state_d = RX_STOP;
          else               bit_d     = bit_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          u_state_d = RX_IDLE;
          if (rx_sync) begin
            byte_stb_d = 1'b1;
            rx_byte_d  = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: u_state_d = RX_IDLE;
    endcase
  end

  // Parser state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_q <= P_IDLE;
      cmd_b_q   <= '0;
      x_b_q     <= '0;
      y_b_q     <= '0;
    end else begin
      p_state_q <= p_state_d;
      cmd_b_q   <= cmd_b_d;
      x_b_q     <= x_b_d;
      y_b_q     <= y_b_d;
    end
  end

  // Parser next state: sync byte opens a packet, later 0xA5 bytes are plain data
  always_comb begin
    p_state_d = p_state_q;
    cmd_b_d   = cmd_b_q;
    x_b_d     = x_b_q;
    y_b_d     = y_b_q;
    pkt_done  = 1'b0;
    tmo_hit   = 1'b0;
    if (frame_err_q) begin
      p_state_d = P_IDLE;
    end else if (byte_stb_q) begin
      case (p_state_q)
        P_IDLE: if (rx_byte_q == SYNC_BYTE) p_state_d = P_CMD;
        P_CMD: begin
          cmd_b_d   = rx_byte_q;
          p_state_d = P_XB;
        end
        P_XB: begin
          x_b_d     = rx_byte_q;
          p_state_d = P_YB;
        end
        P_YB: begin
          y_b_d = rx_byte_q;
`ifdef HID_CHECKSUM_EN
          p_state_d = P_CHK;
`else
          p_state_d = P_IDLE;
          pkt_done  = 1'b1;
`endif
        end
`ifdef HID_CHECKSUM_EN
        P_CHK: begin
          p_state_d = P_IDLE;
          pkt_done  = 1'b1;
        end
`endif
        default: p_state_d = P_IDLE;
      endcase
    end else if ((p_state_q != P_IDLE) && (tmo_q == TMO_LAST)) begin
      tmo_hit   = 1'b1;
      p_state_d = P_IDLE;
    end
  end

  // The final byte is still on rx_byte_q when the packet completes on Y
  assign y_fin = (p_state_q == P_YB) ? rx_byte_q : y_b_q;

`ifdef HID_CHECKSUM_EN
  assign chk_ok = (rx_byte_q == (cmd_b_q ^ x_b_q ^ y_b_q));
`else
  assign chk_ok = 1'b1;
`endif

  assign ranges_ok = fits_width(cmd_b_q, CMD_W) && fits_width(x_b_q, COORD_W) && fits_width(y_fin, COORD_W);
  assign accept    = pkt_done && ranges_ok && chk_ok;
  assign reject    = pkt_done && !accept;
  assign err_inc   = frame_err_q || reject || tmo_hit;

  // Inter-byte gap timer, restarted by every received byte and held clear while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (byte_stb_q || (p_state_q == P_IDLE)) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_LAST) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Register the accepted packet so it is written the cycle after its last byte strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q      <= accept;
      push_data_q <= {cmd_b_q[CMD_W-1:0], x_b_q[COORD_W-1:0], y_fin[COORD_W-1:0]};
    end
  end

  // Saturating error counter and drop indication; a drop on a full FIFO is not an error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      overflow <= push_q && fifo_full && !pop;
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign pop       = cmd_valid && cmd_ready;
  assign cmd_valid = !fifo_empty;
  assign cmd_id    = fifo_rd[ENTRY_W-1 -: CMD_W];
  assign x_out     = fifo_rd[2*COORD_W-1 -: COORD_W];
  assign y_out     = fifo_rd[COORD_W-1:0];

  hid_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (push_data_q),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_hid_packet_rx.sv
// tb/tb_hid_packet_rx.sv - directed self-checking bench for hid_packet_rx (follows HID_CHECKSUM_EN)
module tb_hid_packet_rx;
  import hid_pkg::*;

  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic [5:0] x_out;
  logic [5:0] y_out;
  logic       overflow;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;
  int ovf_cnt = 0;
  logic [14:0] got_q[$];

  always #5 clk = ~clk;

  hid_packet_rx #(
    .CLK_FREQ      (160),
    .BAUD_RATE     (10),
    .CMD_W         (3),
    .COORD_W       (6),
    .FIFO_DEPTH    (4),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .x_out     (x_out),
    .y_out     (y_out),
    .overflow  (overflow),
    .err_count (err_count)
  );

  // Record every handshake and every overflow pulse
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) got_q.push_back({cmd_id, x_out, y_out});
    if (!reset && overflow) ovf_cnt++;
  end

  function automatic logic [14:0] pk(input int c, input int x, input int y);
    hid_cmd_t e;
    e.cmd = 3'(c);
    e.x   = 6'(x);
    e.y   = 6'(y);
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y);
    send_byte(8'hA5, 1'b1);
    send_byte(c, 1'b1);
    send_byte(x, 1'b1);
    send_byte(y, 1'b1);
`ifdef HID_CHECKSUM_EN
    send_byte(c ^ x ^ y, 1'b1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
    vectors++; if (cmd_id !== 3'd0) begin miscompares++; $display("FAIL reset_cmd: got %0d want 0", cmd_id); end
    vectors++; if (x_out !== 6'd0) begin miscompares++; $display("FAIL reset_x: got %0d want 0", x_out); end
    vectors++; if (y_out !== 6'd0) begin miscompares++; $display("FAIL reset_y: got %0d want 0", y_out); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err: got %0d want 0", err_count); end
  endtask

  task automatic test_single();
    int base;
    logic [14:0] e;
    base = got_q.size();
    cmd_ready = 1'b1;
    send_pkt(8'h02, 8'h15, 8'h2A);
    repeat (10) @(negedge clk);
    e = (got_q.size() > base) ? got_q[base] : 15'h7FFF;
    vectors++; if (got_q.size() != base + 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size() - base); end
    vectors++; if (e !== pk(2, 21, 42)) begin miscompares++; $display("FAIL single_entry: got %h want %h", e, pk(2, 21, 42)); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL single_err: got %0d want 0", err_count); end
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained: got %b want 0", cmd_valid); end
  endtask

  task automatic test_bad_packet();
    int base;
    do_reset();
    cmd_ready = 1'b1;
    base = got_q.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h15, 1'b1);
`ifdef HID_CHECKSUM_EN
    send_byte(8'h2A, 1'b1);
    send_byte(8'h00, 1'b1);
`else
    send_byte(8'h40, 1'b1);
`endif
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != base) begin miscompares++; $display("FAIL bad_pkt_count: got %0d want 0", got_q.size() - base); end
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL bad_pkt_err: got %0d want 1", err_count); end
  endtask

  task automatic test_overflow();
    int base;
    int ovf0;
    do_reset();
    cmd_ready = 1'b0;
    base = got_q.size();
    ovf0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_pkt(8'(i), 8'(i + 10), 8'(i + 20));
    repeat (5) @(negedge clk);
    vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid: got %b want 1", cmd_valid); end
    vectors++; if ({cmd_id, x_out, y_out} !== pk(1, 11, 21)) begin miscompares++; $display("FAIL ovf_head: got %h want %h", {cmd_id, x_out, y_out}, pk(1, 11, 21)); end
    vectors++; if (ovf_cnt - ovf0 != 1) begin miscompares++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - ovf0); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL ovf_err: got %0d want 0", err_count); end
    repeat (20) @(negedge clk);
    vectors++; if ({cmd_id, x_out, y_out} !== pk(1, 11, 21)) begin miscompares++; $display("FAIL ovf_hold: got %h want %h", {cmd_id, x_out, y_out}, pk(1, 11, 21)); end
    cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != base + 4) begin miscompares++; $display("FAIL ovf_drain_count: got %0d want 4", got_q.size() - base); end
    for (int k = 0; k < 4; k++) begin
      logic [14:0] e;
      e = (got_q.size() > base + k) ? got_q[base + k] : 15'h7FFF;
      vectors++; if (e !== pk(k + 1, k + 11, k + 21)) begin miscompares++; $display("FAIL ovf_order%0d: got %h want %h", k, e, pk(k + 1, k + 11, k + 21)); end
    end
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got %b want 0", cmd_valid); end
  endtask

  task automatic test_timeout();
    int base;
    logic [14:0] e;
    do_reset();
    cmd_ready = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (500) @(negedge clk);
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL tmo_early: got %0d want 0", err_count); end
    repeat (200) @(negedge clk);
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL tmo_err: got %0d want 1", err_count); end
    base = got_q.size();
    send_pkt(8'h01, 8'h05, 8'h06);
    repeat (10) @(negedge clk);
    e = (got_q.size() > base) ? got_q[base] : 15'h7FFF;
    vectors++; if (e !== pk(1, 5, 6)) begin miscompares++; $display("FAIL tmo_recover: got %h want %h", e, pk(1, 5, 6)); end
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL tmo_err_after: got %0d want 1", err_count); end
  endtask

  task automatic test_range_and_framing();
    int base;
    logic [14:0] e;
    do_reset();
    cmd_ready = 1'b1;
    base = got_q.size();
    send_pkt(8'h09, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL range_err: got %0d want 1", err_count); end
    vectors++; if (got_q.size() != base) begin miscompares++; $display("FAIL range_count: got %0d want 0", got_q.size() - base); end
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL frame_err: got %0d want 2", err_count); end
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL glitch_err: got %0d want 2", err_count); end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (10) @(negedge clk);
    vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL frame_resync_err: got %0d want 3", err_count); end
    vectors++; if (got_q.size() != base) begin miscompares++; $display("FAIL frame_resync_count: got %0d want 0", got_q.size() - base); end
    send_pkt(8'h03, 8'h04, 8'h05);
    repeat (10) @(negedge clk);
    e = (got_q.size() > base) ? got_q[base] : 15'h7FFF;
    vectors++; if (e !== pk(3, 4, 5)) begin miscompares++; $display("FAIL frame_recover: got %h want %h", e, pk(3, 4, 5)); end
  endtask

  task automatic test_boundary();
    int base;
    logic [14:0] e;
    do_reset();
    cmd_ready = 1'b1;
    base = got_q.size();
    send_pkt(8'h07, 8'h3F, 8'h00);
    repeat (10) @(negedge clk);
    e = (got_q.size() > base) ? got_q[base] : 15'h7FFF;
    vectors++; if (e !== pk(7, 63, 0)) begin miscompares++; $display("FAIL max_entry: got %h want %h", e, pk(7, 63, 0)); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL max_err: got %0d want 0", err_count); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [14:0] e;
    do_reset();
    cmd_ready = 1'b0;
    send_pkt(8'h04, 8'h08, 8'h10);
    repeat (4) @(negedge clk);
    vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b want 1", cmd_valid); end
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", cmd_valid); end
    vectors++; if ({cmd_id, x_out, y_out} !== 15'd0) begin miscompares++; $display("FAIL mid_outputs: got %h want 0", {cmd_id, x_out, y_out}); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cmd_ready = 1'b1;
    base = got_q.size();
    send_pkt(8'h05, 8'h09, 8'h21);
    repeat (10) @(negedge clk);
    e = (got_q.size() > base) ? got_q[base] : 15'h7FFF;
    vectors++; if (e !== pk(5, 9, 33)) begin miscompares++; $display("FAIL mid_recover: got %h want %h", e, pk(5, 9, 33)); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL mid_err: got %0d want 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_packet();
    test_overflow();
    test_timeout();
    test_range_and_framing();
    test_boundary();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hid_packet_rx.md
Name: hid_packet_rx

Overview:
- Parametrised successor to the fixed 9600-baud HID front end. Receives a byte stream from the Bluetooth UART link and frames it into sync-prefixed packets.
- Validates each packet and pushes decoded {command, x, y} into a small FIFO.
- Presents FIFO contents to the screen/paint logic over a valid/ready handshake instead of a one-cycle pulse, so back-to-back commands are never lost while the consumer is busy.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz
- BAUD_RATE, 9600, UART bit rate; BIT_TICKS = CLK_FREQ/BAUD_RATE (integer division, 5208 at defaults)
- CMD_W, 3, command field width (1..8)
- COORD_W, 6, x/y width (1..8)
- FIFO_DEPTH, 4, decoded-command FIFO entries (power of two, >= 2)
- TIMEOUT_BYTES, 4, idle gap in byte-times (10*BIT_TICKS each) that aborts a partial packet

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  UART line from BT module, idle high, asynchronous to clk
- cmd_valid  out  1  FIFO non-empty
- cmd_ready  in  1  consumer accepts head entry when cmd_valid && cmd_ready
- cmd_id  out  CMD_W  head-entry command
- x_out  out  COORD_W  head-entry x
- y_out  out  COORD_W  head-entry y
- overflow  out  1  one-cycle pulse: valid packet dropped because FIFO full
- err_count  out  8  saturating count of rejected packets/bytes

Behaviour:
- Reset (async assert, sync deassert handled upstream): FIFO empty; cmd_valid=0; cmd_id/x_out/y_out=0; overflow=0; err_count=0; parser in IDLE; UART in RX_IDLE.
- UART RX, 8N1:
  - rx passes through a 2-flop synchroniser reset to 1.
  - A falling edge starts a BIT_TICKS/2 count. Start bit is re-checked low at mid-point; if high, treat as a glitch and return to idle with no error.
  - Eight data bits sampled LSB first every BIT_TICKS; stop bit sampled once.
  - Stop bit = 0 is a framing error: byte discarded, err_count++, parser forced to IDLE.
  - A good byte raises an internal one-cycle byte strobe.
- Parser states: IDLE, CMD, XB, YB, CHK.
  - IDLE: byte == 0xA5 -> CMD; any other byte is ignored silently.
  - CMD -> XB -> YB capture one byte each.
  - YB -> CHK when HID_CHECKSUM_EN is defined; otherwise packet completes on the YB byte.
  - Packet accepted iff cmd byte < 2^CMD_W, x byte < 2^COORD_W, y byte < 2^COORD_W, and (if enabled) checksum matches. Otherwise err_count++ and return to IDLE.
  - A 0xA5 arriving mid-packet is treated as data, not resync.
  - Timeout: a counter reloads on every byte strobe. It expires after TIMEOUT_BYTES*10*BIT_TICKS clocks in any state other than IDLE, sending the parser to IDLE with err_count++.
- Push: an accepted packet is written in the cycle after its final byte strobe (latency from final stop-bit sample to cmd_valid = 2 clk when the FIFO was empty). If the FIFO is full, the packet is dropped, overflow pulses, and err_count is unchanged.
- Pop: on cmd_valid && cmd_ready the head advances next cycle. Outputs are registered from the head entry and hold stable while cmd_valid && !cmd_ready.
- Simultaneous push and pop when full: pop first, push succeeds, no overflow.
- err_count saturates at 255.

Optional Feature:
- HID_CHECKSUM_EN defined: 5-byte packet 0xA5, CMD, X, Y, CHK, with CHK = CMD ^ X ^ Y; a mismatch rejects the packet.
- Not defined: 4-byte packet, no CHK state, no checksum logic synthesised.

Decomposition:
- Package hid_pkg: SYNC_BYTE = 8'hA5, parser state enum, hid_cmd_t struct {cmd, x, y} sized from CMD_W/COORD_W defaults.
- Natural sub-module: hid_cmd_fifo, a parametrised synchronous FIFO with full/empty flags and simultaneous read/write. UART receive and parser stay in the top.

Test Plan (defaults; checksum enabled unless stated):
- Send A5 02 15 2A 3D with cmd_ready=1 -> one handshake: cmd_id=2, x_out=21, y_out=42; err_count=0.
- Send A5 02 15 2A 00 -> no cmd_valid; err_count=1.
- cmd_ready=0; send 5 valid packets -> cmd_valid stays 1; first 4 retained in order; 5th produces an overflow pulse; raising cmd_ready drains exactly 4 entries.
- Send A5 01 then idle for 4 byte-times (208320 clk) -> err_count=1; a following valid A5 01 05 06 02 is accepted.
- Send A5 09 00 00 09 (cmd out of range for CMD_W=3) -> rejected, err_count=1. Send a byte with stop bit 0 -> err_count=2.
- Build without HID_CHECKSUM_EN; send A5 07 3F 00 -> cmd_id=7, x_out=63, y_out=0. Assert reset mid-byte -> outputs zero immediately; next packet decodes correctly.
